config_chain_loader: RTL and testbench

Serial configuration loader that drives the daisy-chained configuration port of the DSP slice register blocks (configuration_input / configuration_enable in, configuration_output back from the chain tail). It accepts the bitstream as parallel words over a valid/ready handshake and serializes exactly CHAIN_LEN bits into the chain. It can then run an optional non-destructive read-back pass that rotates the chain once and checks every bit.

---
 rtl/config_chain_loader_if.sv | 12 +
 rtl/config_chain_loader.sv | 163 ++++++++++++++++
 tb/tb_config_chain_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_chain_loader_if.sv
// Parallel bitstream word stream feeding config_chain_loader (valid/ready handshake).
// The LSB of s_data is the first bit shifted into the configuration chain.
interface config_chain_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Serializes CHAIN_LEN configuration bits into a DSP-slice register daisy chain from a word
// stream, with an optional read-back pass that rotates the chain once and checks each bit.
module config_chain_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                 clk,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic                 verify_en,
  input  logic                 abort,
  config_chain_loader_if.slave s_if,
  output logic                 configuration_input,
  output logic                 configuration_enable,
  input  logic                 configuration_output,
  output logic                 busy,
  output logic                 done,
  output logic                 verify_error
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_VERIFY,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WORD_W-1:0]   r_word;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CHAIN_LEN-1:0] r_expected;
  logic                r_verify_en;
  logic                r_verify_error;

  logic w_last_chain;
  logic w_last_word;
  logic w_ready;
  logic w_enable;
  logic w_cin;
  logic w_start_acc;
  logic w_capture;

  // r_cnt counts bits sent during SHIFT and rotate cycles during VERIFY.
  assign w_last_chain = (r_cnt == LAST_BIT);
  assign w_last_word  = (r_wcnt == LAST_WBIT);

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_enable    = 1'b0;
    w_cin       = 1'b0;
    w_start_acc = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (s_if.s_valid) begin
          w_capture = 1'b1;
          w_next    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_enable = 1'b1;
        w_cin    = r_word[0];
        if (w_last_chain) begin
          w_next = r_verify_en ? S_VERIFY : S_DONE;
        end else if (w_last_word) begin
          // Offering the next word on the last bit keeps back-to-back words gap-free.
          w_ready = 1'b1;
          if (s_if.s_valid) begin
            w_capture = 1'b1;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      S_VERIFY: begin
        w_enable = 1'b1;
        w_cin    = configuration_output;
        if (w_last_chain) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Abort wins over a handshake and over start in the same cycle.
    if (abort) begin
      w_next      = S_IDLE;
      w_ready     = 1'b0;
      w_capture   = 1'b0;
      w_start_acc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_word         <= '0;
      r_wcnt         <= '0;
      r_cnt          <= '0;
      r_expected     <= '0;
      r_verify_en    <= 1'b0;
      r_verify_error <= 1'b0;
    end else if (abort) begin
      r_verify_error <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_cnt          <= '0;
        r_verify_en    <= verify_en;
        r_verify_error <= 1'b0;
      end
      if (w_capture) begin
        r_word <= s_if.s_data;
        r_wcnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_word <= r_word >> 1;
        r_wcnt <= r_wcnt + 1'b1;
      end
      // Expected image fills from the top so bit k lands at index k after CHAIN_LEN pushes;
      // the verify pass rotates it in step with the chain, leaving it intact afterwards.
      if (r_state == S_SHIFT) begin
        r_expected <= CHAIN_LEN'({r_word[0], r_expected} >> 1);
        r_cnt      <= w_last_chain ? '0 : r_cnt + 1'b1;
      end
      if (r_state == S_VERIFY) begin
        r_expected <= CHAIN_LEN'({r_expected[0], r_expected} >> 1);
        r_cnt      <= r_cnt + 1'b1;
        if (configuration_output != r_expected[0]) begin
          r_verify_error <= 1'b1;
        end
      end
    end
  end

  assign s_if.s_ready         = w_ready;
  assign configuration_enable = w_enable;
  assign configuration_input  = w_cin;
  assign busy                 = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_VERIFY);
  assign done                 = (r_state == S_DONE);
  assign verify_error         = r_verify_error;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 20-bit and a 2-bit chain model driven by word streams,
// compared against bit sequences derived directly from the loaded words.
module tb_config_chain_loader;

  localparam int unsigned L  = 20;
  localparam int unsigned LS = 2;

  logic clk = 1'b0;
  logic RST_N;
  logic start20, vfy20, abort20;
  logic start2, vfy2, abort2;
  logic cin20, en20, cout20, busy20, done20, verr20;
  logic cin2, en2, cout2, busy2, done2, verr2;
  logic [L-1:0]  chain20 = '0;
  logic [L-1:0]  stuck20 = '0;
  logic [LS-1:0] chain2  = '0;

  config_chain_loader_if #(.WORD_W(8)) if20 ();
  config_chain_loader_if #(.WORD_W(8)) if2 ();

  config_chain_loader #(.CHAIN_LEN(L), .WORD_W(8)) dut20 (
    .clk(clk), .RST_N(RST_N), .start(start20), .verify_en(vfy20), .abort(abort20),
    .s_if(if20), .configuration_input(cin20), .configuration_enable(en20),
    .configuration_output(cout20), .busy(busy20), .done(done20), .verify_error(verr20)
  );

  config_chain_loader #(.CHAIN_LEN(LS), .WORD_W(8)) dut2 (
    .clk(clk), .RST_N(RST_N), .start(start2), .verify_en(vfy2), .abort(abort2),
    .s_if(if2), .configuration_input(cin2), .configuration_enable(en2),
    .configuration_output(cout2), .busy(busy2), .done(done2), .verify_error(verr2)
  );

  always #5 clk = ~clk;

  // Chain models: head at index 0, tail (registered output) at the top index.
  assign cout20 = chain20[L-1];
  assign cout2  = chain2[LS-1];
  always @(posedge clk) if (en20) chain20 <= {chain20[L-2:0], cin20} & ~stuck20;
  always @(posedge clk) if (en2)  chain2  <= {chain2[0], cin2};

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] words[3];
  bit   exp_q[$];
  bit   q_bits[$];
  int   en_idx[$];
  int   hs_cnt, hs_en_cnt, vfy_cnt, late_ready, done_cyc;
  bit   timed_out, first_ready;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the chain receives the words LSB first, truncated to n bits in total.
  task automatic build_ref(input int n);
    exp_q.delete();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 8; j++)
        if (exp_q.size() < n) exp_q.push_back(words[i][j]);
  endtask

  function automatic logic [L-1:0] got_vec();
    logic [L-1:0] v = '0;
    for (int k = 0; k < q_bits.size() && k < L; k++) v[k] = q_bits[k];
    return v;
  endfunction

  function automatic logic [L-1:0] exp_vec();
    logic [L-1:0] v = '0;
    for (int k = 0; k < exp_q.size() && k < L; k++) v[k] = exp_q[k];
    return v;
  endfunction

  // Chain contents in send order: bit k sits k places from the tail.
  function automatic logic [L-1:0] img_vec();
    logic [L-1:0] v = '0;
    for (int k = 0; k < L; k++) v[k] = chain20[L-1-k];
    return v;
  endfunction

  function automatic void rand_words();
    for (int i = 0; i < 3; i++) words[i] = 8'($urandom);
  endfunction

  // Drives one session on the 20-bit DUT; after every handshake the stream withholds the next
  // word for `stall` cycles in which the loader is ready. stop_at>0 returns on that enable cycle.
  task automatic run20(input int stall, input bit v, input int stop_at);
    int wi = 0;
    int stall_left = 0;
    int n_en = 0;
    q_bits.delete();
    en_idx.delete();
    hs_cnt = 0; hs_en_cnt = 0; vfy_cnt = 0; late_ready = 0; done_cyc = -1;
    timed_out = 1'b1;
    start20 = 1'b1; vfy20 = v;
    step();
    start20 = 1'b0; vfy20 = 1'b0;
    first_ready = if20.s_ready;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done20) begin done_cyc = cyc; timed_out = 1'b0; break; end
      if (en20) begin
        n_en++;
        en_idx.push_back(cyc);
        if (n_en <= L) q_bits.push_back(cin20); else vfy_cnt++;
      end
      if (n_en >= L && if20.s_ready) late_ready++;
      if (stop_at != 0 && n_en == stop_at) begin timed_out = 1'b0; break; end
      if (wi < 3 && stall_left == 0) begin
        if20.s_valid = 1'b1; if20.s_data = words[wi];
      end else begin
        if20.s_valid = 1'b0; if20.s_data = 8'($urandom);
        if (if20.s_ready && stall_left > 0) stall_left--;
      end
      if (if20.s_valid && if20.s_ready) begin
        hs_cnt++;
        if (en20) hs_en_cnt++;
        wi++;
        stall_left = stall;
      end
      step();
    end
    if20.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({if20.s_ready, en20, cin20, busy20, done20, verr20} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset20: got ready/en/in/busy/done/verr=%b want 000000",
               {if20.s_ready, en20, cin20, busy20, done20, verr20});
    end
    n_checks++;
    if ({if2.s_ready, en2, cin2, busy2, done2, verr2} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset2: got ready/en/in/busy/done/verr=%b want 000000",
               {if2.s_ready, en2, cin2, busy2, done2, verr2});
    end
  endtask

  task automatic test_short_chain();
    bit   q2[$];
    int   late = 0;
    bit   fin = 1'b0;
    logic [1:0] g2 = '0;
    logic [1:0] e2 = '0;
    words[0] = 8'h01; words[1] = 8'h00; words[2] = 8'h00;
    build_ref(LS);
    start2 = 1'b1; vfy2 = 1'b0;
    step();
    start2 = 1'b0;
    n_checks++;
    if (if2.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL short_load_ready: got %b want 1", if2.s_ready);
    end
    if2.s_valid = 1'b1; if2.s_data = 8'h01;
    step();
    if2.s_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done2) begin fin = 1'b1; break; end
      if (en2) q2.push_back(cin2);
      if (if2.s_ready) late++;
      step();
    end
    for (int k = 0; k < q2.size() && k < 2; k++) g2[k] = q2[k];
    for (int k = 0; k < 2; k++) e2[k] = exp_q[k];
    n_checks++;
    if (q2.size() != 2 || g2 !== e2) begin
      n_fail++; $display("FAIL short_bits: got %0d enables bits %b want 2 enables bits %b", q2.size(), g2, e2);
    end
    n_checks++;
    if (chain2 !== 2'b10) begin
      n_fail++; $display("FAIL short_chain: got tail/head=%b want 10", chain2);
    end
    n_checks++;
    if (!fin || done2 !== 1'b1 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL short_done: got done=%b busy=%b want 1 0", done2, busy2);
    end
    n_checks++;
    if (late != 0 || if2.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL short_ready_after: got %0d ready cycles want 0", late);
    end
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] g;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    build_ref(L);
    run20(0, 1'b0, 0);
    g = got_vec();
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL b2b_timeout: got no done within budget want done"); end
    n_checks++;
    if (first_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_load_ready: got %b want 1", first_ready); end
    n_checks++;
    if (q_bits.size() != L || g !== exp_vec()) begin
      n_fail++; $display("FAIL b2b_bits: got %0d bits %h want %0d bits %h", q_bits.size(), g, L, exp_vec());
    end
    n_checks++;
    if (g[19:16] !== 4'b1111) begin n_fail++; $display("FAIL b2b_last_word: got %b want 1111", g[19:16]); end
    n_checks++;
    if (en_idx.size() != L || en_idx[L-1] - en_idx[0] != L - 1) begin
      n_fail++; $display("FAIL b2b_gap: got %0d enables not contiguous want %0d contiguous", en_idx.size(), L);
    end
    n_checks++;
    if (hs_cnt != 3 || hs_en_cnt != 2) begin
      n_fail++; $display("FAIL b2b_handshake: got %0d hs (%0d on shift) want 3 (2 on shift)", hs_cnt, hs_en_cnt);
    end
    n_checks++;
    if (en_idx.size() == 0 || done20 !== 1'b1 || busy20 !== 1'b0 || done_cyc != en_idx[$] + 1) begin
      n_fail++; $display("FAIL b2b_done: got done=%b busy=%b at cyc %0d want 1 0 after last shift", done20, busy20, done_cyc);
    end
    n_checks++;
    if (img_vec() !== exp_vec()) begin n_fail++; $display("FAIL b2b_image: got %h want %h", img_vec(), exp_vec()); end
    n_checks++;
    if (late_ready != 0) begin n_fail++; $display("FAIL b2b_ready_after: got %0d ready cycles want 0", late_ready); end
  endtask

  task automatic test_stall();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    build_ref(L);
    run20(5, 1'b0, 0);
    n_checks++;
    if (timed_out || q_bits.size() != L || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL stall_bits: got %0d bits %h want %0d bits %h", q_bits.size(), got_vec(), L, exp_vec());
    end
    n_checks++;
    if (en_idx.size() != L || en_idx[L-1] - en_idx[0] != L - 1 + 2 * 5) begin
      n_fail++; $display("FAIL stall_span: got %0d enables want %0d over span %0d", en_idx.size(), L, L - 1 + 10);
    end
    n_checks++;
    if (hs_cnt != 3 || hs_en_cnt != 0) begin
      n_fail++; $display("FAIL stall_handshake: got %0d hs (%0d on shift) want 3 (0 on shift)", hs_cnt, hs_en_cnt);
    end
    n_checks++;
    if (done20 !== 1'b1 || img_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL stall_image: got done=%b image %h want 1 %h", done20, img_vec(), exp_vec());
    end
  endtask

  task automatic test_verify();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    build_ref(L);
    run20(0, 1'b1, 0);
    n_checks++;
    if (timed_out || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL verify_bits: got %h want %h", got_vec(), exp_vec());
    end
    n_checks++;
    if (vfy_cnt != L || en_idx.size() != 2 * L || en_idx[2*L-1] - en_idx[0] != 2 * L - 1) begin
      n_fail++; $display("FAIL verify_rotate: got %0d rotate cycles want %0d contiguous", vfy_cnt, L);
    end
    n_checks++;
    if (verr20 !== 1'b0 || done20 !== 1'b1) begin
      n_fail++; $display("FAIL verify_clean: got verr=%b done=%b want 0 1", verr20, done20);
    end
    n_checks++;
    if (img_vec() !== exp_vec()) begin n_fail++; $display("FAIL verify_image: got %h want %h", img_vec(), exp_vec()); end
  endtask

  task automatic test_verify_fault();
    int k1 = 0;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    build_ref(L);
    while (k1 < L - 1 && exp_q[k1] == 1'b0) k1++;
    stuck20 = '0;
    stuck20[L-1-k1] = 1'b1;
    run20(0, 1'b1, 0);
    n_checks++;
    if (timed_out || vfy_cnt != L) begin
      n_fail++; $display("FAIL fault_rotate: got %0d rotate cycles want %0d", vfy_cnt, L);
    end
    n_checks++;
    if (verr20 !== 1'b1 || done20 !== 1'b1) begin
      n_fail++; $display("FAIL fault_flag: got verr=%b done=%b want 1 1", verr20, done20);
    end
    repeat (3) step();
    n_checks++;
    if (verr20 !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b want 1", verr20); end
    stuck20 = '0;
  endtask

  task automatic test_abort();
    rand_words();
    run20(0, 1'b0, 7);
    n_checks++;
    if (timed_out || en20 !== 1'b1) begin n_fail++; $display("FAIL abort_reach: got en=%b want 1", en20); end
    abort20 = 1'b1;
    step();
    abort20 = 1'b0;
    n_checks++;
    if ({en20, busy20, done20, if20.s_ready, verr20} !== 5'b0) begin
      n_fail++; $display("FAIL abort_idle: got en/busy/done/ready/verr=%b want 00000",
                         {en20, busy20, done20, if20.s_ready, verr20});
    end
    repeat (2) step();
    n_checks++;
    if (en20 !== 1'b0 || busy20 !== 1'b0) begin
      n_fail++; $display("FAIL abort_hold: got en=%b busy=%b want 0 0", en20, busy20);
    end
    rand_words();
    build_ref(L);
    run20(0, 1'b1, 0);
    n_checks++;
    if (timed_out || got_vec() !== exp_vec() || img_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL abort_reload: got bits %h image %h want %h", got_vec(), img_vec(), exp_vec());
    end
    n_checks++;
    if (verr20 !== 1'b0 || done20 !== 1'b1) begin
      n_fail++; $display("FAIL abort_reload_done: got verr=%b done=%b want 0 1", verr20, done20);
    end
  endtask

  task automatic test_reset_midshift();
    rand_words();
    run20(0, 1'b0, 9);
    RST_N = 1'b0;
    #1;
    n_checks++;
    if ({if20.s_ready, en20, cin20, busy20, done20, verr20} !== 6'b0) begin
      n_fail++; $display("FAIL rst_mid: got ready/en/in/busy/done/verr=%b want 000000",
                         {if20.s_ready, en20, cin20, busy20, done20, verr20});
    end
    step();
    step();
    RST_N = 1'b1;
    step();
    n_checks++;
    if (busy20 !== 1'b0 || en20 !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_resume: got busy=%b en=%b want 0 0", busy20, en20);
    end
    rand_words();
    build_ref(L);
    run20(0, 1'b0, 0);
    n_checks++;
    if (timed_out || en_idx.size() != L || got_vec() !== exp_vec() || img_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL rst_reload: got %0d enables bits %h image %h want %0d %h",
                         en_idx.size(), got_vec(), img_vec(), L, exp_vec());
    end
  endtask

  task automatic test_random();
    int st;
    bit v;
    for (int s = 0; s < 4; s++) begin
      rand_words();
      st = int'($urandom_range(0, 3));
      v  = 1'($urandom_range(0, 1));
      build_ref(L);
      run20(st, v, 0);
      n_checks++;
      if (timed_out || got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand%0d_bits: got %h want %h", s, got_vec(), exp_vec());
      end
      n_checks++;
      if (en_idx.size() != (v ? 2 * L : L) || en_idx[L-1] - en_idx[0] != L - 1 + 2 * st) begin
        n_fail++; $display("FAIL rand%0d_timing: got %0d enables want %0d with stall %0d", s, en_idx.size(), v ? 2 * L : L, st);
      end
      n_checks++;
      if (done20 !== 1'b1 || verr20 !== 1'b0 || en_idx.size() == 0 || done_cyc != en_idx[$] + 1) begin
        n_fail++; $display("FAIL rand%0d_done: got done=%b verr=%b want 1 0", s, done20, verr20);
      end
      n_checks++;
      if (img_vec() !== exp_vec()) begin n_fail++; $display("FAIL rand%0d_image: got %h want %h", s, img_vec(), exp_vec()); end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    start20 = 1'b0; vfy20 = 1'b0; abort20 = 1'b0;
    start2 = 1'b0; vfy2 = 1'b0; abort2 = 1'b0;
    if20.s_valid = 1'b0; if20.s_data = '0;
    if2.s_valid = 1'b0; if2.s_data = '0;
    #12;
    test_reset();
    RST_N = 1'b1;
    step();
    test_short_chain();
    test_back_to_back();
    test_stall();
    test_verify();
    test_verify_fault();
    test_abort();
    test_reset_midshift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
